// File: rtl/sum_collector.sv
// sum_collector: batches NUM_SAMPLES 5-bit adder results into a saturating total with carry count.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + sum1..sum4,c_out form the sample input;
// clear aborts the batch; out_valid/out_ready release the batch; acc_out, carry_cnt, ovf report it.
module sum_collector #(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sum1,
  input  logic             sum2,
  input  logic             sum3,
  input  logic             sum4,
  input  logic             c_out,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [3:0]       carry_cnt,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic [ACC_W:0] total;
  assign cnt_next = cnt + 4'd1;
  // One extra bit on the sum exposes overflow for saturation.
  assign total = {1'b0, acc_out} + {{(ACC_W-4){1'b0}}, c_out, sum4, sum3, sum2, sum1};
  always_ff @(posedge clk) begin
    if (rst || clear || (state == DONE && out_ready)) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_out   <= '0;
      carry_cnt <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (state != DONE && in_valid) begin
      acc_out   <= total[ACC_W] ? '1 : total[ACC_W-1:0];
      ovf       <= ovf | total[ACC_W];
      carry_cnt <= carry_cnt + {3'b0, c_out};
      cnt       <= cnt_next;
      state     <= (cnt_next == 4'(NUM_SAMPLES)) ? DONE : ACC;
      in_ready  <= cnt_next != 4'(NUM_SAMPLES);
      out_valid <= cnt_next == 4'(NUM_SAMPLES);
    end
  end
endmodule

// File: doc/sum_collector.md
SUM_COLLECTOR -- requirements
Module: sum_collector

Interface
REQ-001 Parameter NUM_SAMPLES, default 4: number of adder results accumulated per batch; legal range 1..15.
REQ-002 Parameter ACC_W, default 8: accumulator width in bits; minimum 5.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset; sampled only on the rising clk edge.
REQ-005 in_valid  input  1  upstream 4-bit ripple-carry adder result is present this cycle.
REQ-006 in_ready  output  1  block SHALL accept a result this cycle.
REQ-007 sum1, sum2, sum3, sum4  input  1 each  adder sum bits; sum1 = LSB, sum4 = MSB.
REQ-008 c_out  input  1  adder carry-out; weight 16.
REQ-009 clear  input  1  synchronous batch abort.
REQ-010 out_valid  output  1  completed batch total is presented.
REQ-011 out_ready  input  1  downstream consumes the batch total.
REQ-012 acc_out  output  ACC_W  running or final total.
REQ-013 carry_cnt  output  4  count of accepted samples in the current batch with c_out=1.
REQ-014 ovf  output  1  sticky saturation flag for the current batch.

Function
REQ-015 Sample value SHALL be the 5-bit unsigned {c_out,sum4,sum3,sum2,sum1}, zero-extended to ACC_W bits.
REQ-016 Accept event: in_valid=1 and in_ready=1 at a rising edge.
REQ-017 FSM states: IDLE (no samples held), ACC (1..NUM_SAMPLES-1 samples held), DONE (batch complete).
REQ-018 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE; out_valid SHALL be 1 only in DONE.
REQ-019 On an accept, acc_out SHALL update at the same edge to acc_out+sample; the sample count SHALL increment; carry_cnt SHALL increment if c_out=1.
REQ-020 If acc_out+sample exceeds 2^ACC_W-1, acc_out SHALL saturate to all ones and ovf SHALL set; ovf SHALL hold until the batch is released.
REQ-021 IDLE->ACC on an accept when NUM_SAMPLES>1; IDLE->DONE on an accept when NUM_SAMPLES=1.
REQ-022 ACC->DONE on the accept that brings the count to NUM_SAMPLES; out_valid SHALL be high in the cycle after that edge (latency 1).
REQ-023 DONE: acc_out, carry_cnt and ovf SHALL hold while out_ready=0; in_valid SHALL be ignored.
REQ-024 DONE with out_ready=1 SHALL move to IDLE at that edge and zero acc_out, carry_cnt, ovf and the count.
REQ-025 A sample SHALL NOT be accepted on the same edge as a DONE release; the first sample of the next batch is accepted no earlier than the following edge.
REQ-026 clear=1 in any state SHALL force IDLE and zero acc_out, carry_cnt, ovf and the count; clear SHALL override any simultaneous accept or release.
REQ-027 Priority at each edge: rst > clear > release/accept > hold.

Reset
REQ-028 While rst=1 at an edge, the block SHALL enter IDLE with acc_out=0, carry_cnt=0, ovf=0, out_valid=0, in_ready=1 and count=0.
REQ-029 rst SHALL abort a batch in any state, including DONE with out_ready=1; no release handshake SHALL be considered completed.

Verification
REQ-030 Assert rst for 2 cycles, then deassert -> acc_out=0, carry_cnt=0, ovf=0, out_valid=0, in_ready=1.
REQ-031 Defaults, accept samples 5, 10, 15, 31 (c_out=1 only on 31) on consecutive cycles -> next cycle out_valid=1, acc_out=61, carry_cnt=1, ovf=0, in_ready=0.
REQ-032 In DONE, hold out_ready=0 for 3 cycles with in_valid=1 -> outputs unchanged and no accept; then out_ready=1 for one edge -> IDLE, acc_out=0, in_ready=1.
REQ-033 ACC_W=5, NUM_SAMPLES=2, samples 20 and 20 -> acc_out=31, ovf=1, out_valid=1.
REQ-034 Defaults, accept 2 samples, then clear=1 together with in_valid=1 -> IDLE, acc_out=0, sample dropped; 4 further samples of 1 -> acc_out=4.
REQ-035 In DONE, assert rst and out_ready together -> IDLE with all outputs at reset values; no residual out_valid.
